// File: rtl/multibit_stream_pkg.sv
// Shared types and elaboration helpers for the multibit stream width converters.
package multibit_stream_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic int ratio_f(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // A one-beat word still needs a 1-bit counter so the port widths stay legal.
    function automatic int cnt_w_f(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/multibit_stream_downsizer.sv
// Wide-to-narrow stream converter: one DATA_WIDTH word in, RATIO OUT_WIDTH beats out,
// least-significant slice first, with no bubble between consecutive words.
module multibit_stream_downsizer
    import multibit_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int RATIO = ratio_f(DATA_WIDTH, OUT_WIDTH);
    localparam int CNT_W = cnt_w_f(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    if ((DATA_WIDTH % OUT_WIDTH) != 0 || RATIO < 1) begin : g_bad_width
        $error("multibit_stream_downsizer: DATA_WIDTH must be a positive multiple of OUT_WIDTH");
    end

    state_t                state;
    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_last;
    logic [CNT_W-1:0]      cnt;
    logic                  full;
    logic                  at_last;
    logic                  final_beat;

    assign full       = (state == DRAIN);
    assign at_last    = (cnt == LAST_CNT);
    assign final_beat = full && m_ready && at_last;

    // The only combinational path through the block: m_ready lets a new word in
    // on the same edge that retires the last beat of the current one.
    assign s_ready = !full || final_beat;
    assign m_valid = full;
    assign m_last  = full && hold_last && at_last;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state     <= EMPTY;
            cnt       <= '0;
            hold_last <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (s_valid) begin
                        state     <= DRAIN;
                        cnt       <= '0;
                        hold_last <= s_last;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (at_last) begin
                            if (s_valid) begin
                                cnt       <= '0;
                                hold_last <= s_last;
                            end else begin
                                state <= EMPTY;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // NOTE: the holding register is deliberately left out of reset; its contents
    // are never observed while EMPTY, so a reset would only cost routing.
    always_ff @(posedge clk) begin
        if (s_valid && s_ready) begin
            hold <= s_data;
        end
    end

    if (RATIO == 1) begin : g_single
        assign m_data = hold;
    end else begin : g_multi
        logic [OUT_WIDTH-1:0] slice [RATIO];
        for (genvar i = 0; i < RATIO; i++) begin : g_slice
            assign slice[i] = hold[i*OUT_WIDTH +: OUT_WIDTH];
        end
        assign m_data = slice[cnt];
    end

endmodule

// File: tb/tb_multibit_stream_downsizer.sv
// Scoreboard bench for multibit_stream_downsizer: a 32->8 instance and a 32->32 slice.
module tb_multibit_stream_downsizer;

    logic        clk;
    logic        reset;

    logic        s_valid, s_last, s_ready, m_valid, m_last, m_ready;
    logic [31:0] s_data;
    logic [7:0]  m_data;

    logic        s_valid1, s_last1, s_ready1, m_valid1, m_last1, m_ready1;
    logic [31:0] s_data1;
    logic [31:0] m_data1;

    int vectors;
    int miscompares;

    logic [8:0]  q8 [$];
    logic [32:0] q1 [$];

    multibit_stream_downsizer #(.DATA_WIDTH(32), .OUT_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    multibit_stream_downsizer #(.DATA_WIDTH(32), .OUT_WIDTH(32)) dut1 (
        .clk(clk), .reset(reset),
        .s_valid(s_valid1), .s_data(s_data1), .s_last(s_last1), .s_ready(s_ready1),
        .m_valid(m_valid1), .m_data(m_data1), .m_last(m_last1), .m_ready(m_ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at the falling edge: retire beats handshaking on the coming rising
    // edge, then queue the beats of any word accepted on that same edge.
    task automatic sb_step();
        logic [8:0]  e8;
        logic [32:0] e1;
        if (reset) begin
            q8.delete();
            q1.delete();
            return;
        end
        if (m_valid && m_ready) begin
            vectors++;
            if (q8.size() == 0) begin
                miscompares++;
                $display("FAIL sb8_extra: got last=%b data=%h, expected no beat", m_last, m_data);
            end else begin
                e8 = q8.pop_front();
                if ({m_last, m_data} !== e8) begin
                    miscompares++;
                    $display("FAIL sb8_beat: got last=%b data=%h, expected last=%b data=%h",
                             m_last, m_data, e8[8], e8[7:0]);
                end
            end
        end
        if (s_valid && s_ready)
            for (int i = 0; i < 4; i++) q8.push_back({s_last && (i == 3), s_data[i*8 +: 8]});
        if (m_valid1 && m_ready1) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL sb1_extra: got last=%b data=%h, expected no beat", m_last1, m_data1);
            end else begin
                e1 = q1.pop_front();
                if ({m_last1, m_data1} !== e1) begin
                    miscompares++;
                    $display("FAIL sb1_beat: got last=%b data=%h, expected last=%b data=%h",
                             m_last1, m_data1, e1[32], e1[31:0]);
                end
            end
        end
        if (s_valid1 && s_ready1) q1.push_back({s_last1, s_data1});
    endtask

    task automatic settle();
        @(negedge clk);
        sb_step();
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b1; s_data = 32'hCAFEF00D; s_last = 1'b1; m_ready = 1'b1;
        edge_();
        for (int i = 0; i < 2; i++) begin
            settle();
            vectors++;
            if ({m_valid, m_last, s_ready} !== 3'b001) begin
                miscompares++;
                $display("FAIL reset_hold: got valid/last/ready=%b%b%b, expected 001", m_valid, m_last, s_ready);
            end
            if (i == 0) edge_();
        end
        edge_();
        reset = 1'b0; s_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            vectors++;
            if ({m_valid, m_last, s_ready} !== 3'b001) begin
                miscompares++;
                $display("FAIL reset_nocapture: got valid/last/ready=%b%b%b, expected 001", m_valid, m_last, s_ready);
            end
            edge_();
        end
    endtask

    task automatic test_single_word();
        logic [31:0] word;
        word = 32'hDDCCBBAA;
        s_valid = 1'b1; s_data = word; s_last = 1'b1; m_ready = 1'b1;
        settle();
        vectors++;
        if (s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_accept: got s_ready=%b, expected 1", s_ready);
        end
        edge_();
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            vectors++;
            if ({m_valid, m_last, s_ready, m_data} !== {1'b1, i == 3, i == 3, word[i*8 +: 8]}) begin
                miscompares++;
                $display("FAIL single_beat%0d: got valid=%b last=%b ready=%b data=%h, expected 1 %b %b %h",
                         i, m_valid, m_last, s_ready, m_data, i == 3, i == 3, word[i*8 +: 8]);
            end
            edge_();
        end
        settle();
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: got m_valid=%b, expected 0", m_valid);
        end
        edge_();
    endtask

    task automatic test_back_to_back();
        s_valid = 1'b1; s_data = 32'h03020100; s_last = 1'b0; m_ready = 1'b1;
        settle();
        edge_();
        s_data = 32'h07060504; s_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle();
            vectors++;
            if ({m_valid, m_last, m_data} !== {1'b1, i == 7, 8'(i)}) begin
                miscompares++;
                $display("FAIL b2b_beat%0d: got valid=%b last=%b data=%h, expected 1 %b %h",
                         i, m_valid, m_last, m_data, i == 7, 8'(i));
            end
            if (i < 4) begin
                vectors++;
                if (s_ready !== (i == 3)) begin
                    miscompares++;
                    $display("FAIL b2b_ready%0d: got s_ready=%b, expected %b", i, s_ready, i == 3);
                end
            end
            edge_();
            if (i == 3) s_valid = 1'b0;
        end
        settle();
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got m_valid=%b, expected 0", m_valid);
        end
        edge_();
    endtask

    task automatic test_backpressure();
        logic [31:0] word;
        int k;
        int c;
        word = 32'h44332211;
        s_valid = 1'b1; s_data = word; s_last = 1'b0; m_ready = 1'b1;
        settle();
        edge_();
        s_valid = 1'b0;
        k = 0;
        c = 0;
        while (k < 4 && c < 24) begin
            m_ready = (c % 3 == 0);
            settle();
            vectors++;
            if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, word[k*8 +: 8]}) begin
                miscompares++;
                $display("FAIL bp_cycle%0d: got valid=%b last=%b data=%h, expected 1 0 %h",
                         c, m_valid, m_last, m_data, word[k*8 +: 8]);
            end
            if (m_ready) k++;
            edge_();
            c++;
        end
        vectors++;
        if (k != 4) begin
            miscompares++;
            $display("FAIL bp_timeout: got %0d beats, expected 4", k);
        end
        m_ready = 1'b1;
        settle();
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_idle: got m_valid=%b, expected 0", m_valid);
        end
        edge_();
    endtask

    task automatic test_reset_mid_word();
        s_valid = 1'b1; s_data = 32'hDDCCBBAA; s_last = 1'b1; m_ready = 1'b1;
        settle();
        edge_();
        s_valid = 1'b0;
        settle(); edge_();
        settle(); edge_();
        reset = 1'b1; m_ready = 1'b0;
        settle();
        edge_();
        reset = 1'b0; m_ready = 1'b1;
        s_valid = 1'b1; s_data = 32'h11111111; s_last = 1'b0;
        settle();
        vectors++;
        if ({m_valid, s_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL midrst_empty: got valid/ready=%b%b, expected 01", m_valid, s_ready);
        end
        edge_();
        s_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            vectors++;
            if ({m_valid, m_last, m_data} !== ((i < 4) ? {2'b10, 8'h11} : {2'b00, m_data})) begin
                miscompares++;
                $display("FAIL midrst_beat%0d: got valid=%b last=%b data=%h, expected valid=%b last=0 data=11",
                         i, m_valid, m_last, m_data, i < 4);
            end
            edge_();
        end
    endtask

    task automatic test_ratio_one();
        logic        stall;
        logic [32:0] prev;
        stall = 1'b0;
        prev  = '0;
        for (int c = 0; c < 1000; c++) begin
            s_valid1 = 1'($urandom_range(0, 1));
            s_data1  = $urandom;
            s_last1  = 1'($urandom_range(0, 1));
            m_ready1 = 1'($urandom_range(0, 1));
            settle();
            if (stall) begin
                vectors++;
                if ({m_valid1, m_last1, m_data1} !== {1'b1, prev}) begin
                    miscompares++;
                    $display("FAIL r1_stable%0d: got valid=%b last=%b data=%h, expected 1 %b %h",
                             c, m_valid1, m_last1, m_data1, prev[32], prev[31:0]);
                end
            end
            stall = m_valid1 && !m_ready1;
            prev  = {m_last1, m_data1};
            edge_();
        end
        s_valid1 = 1'b0; m_ready1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            edge_();
        end
        vectors++;
        if (q1.size() != 0 || q8.size() != 0) begin
            miscompares++;
            $display("FAIL drain_empty: got %0d/%0d beats outstanding, expected 0/0", q1.size(), q8.size());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        s_valid1 = 1'b0; s_data1 = '0; s_last1 = 1'b0; m_ready1 = 1'b1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_ratio_one();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
